// File: rtl/vga_rect_fill_writer.sv
// Rectangle-fill write engine: accepts a clipped fill command and streams one pixel per
// accepted write into the COLS x ROWS video memory, row-major.
module vga_rect_fill_writer #(
  parameter int unsigned COLOR_DEPTH = 3,
  parameter int unsigned nX          = 8,
  parameter int unsigned nY          = 7,
  parameter int unsigned Mn          = 15,
  parameter int unsigned COLS        = 160,
  parameter int unsigned ROWS        = 120
) (
  input  logic                   vga_clock,
  input  logic                   resetn,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [nX-1:0]          cmd_x0_i,
  input  logic [nY-1:0]          cmd_y0_i,
  input  logic [nX-1:0]          cmd_w_i,
  input  logic [nY-1:0]          cmd_h_i,
  input  logic [COLOR_DEPTH-1:0] cmd_color_i,
  input  logic                   wr_ready_i,
  output logic                   wr_en_o,
  output logic [Mn-1:0]          wr_addr_o,
  output logic [COLOR_DEPTH-1:0] wr_data_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam logic [nX:0]   ColsX = (nX+1)'(COLS);
  localparam logic [nY:0]   RowsY = (nY+1)'(ROWS);
  localparam logic [Mn-1:0] ColsM = Mn'(COLS);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e                 state_q, state_d;
  logic [nX-1:0]          x0_q, x0_d;
  logic [nX-1:0]          x_end_q, x_end_d;
  logic [nY-1:0]          y_end_q, y_end_d;
  logic [nX-1:0]          cur_x_q, cur_x_d;
  logic [nY-1:0]          cur_y_q, cur_y_d;
  logic [COLOR_DEPTH-1:0] color_q, color_d;

  // Clipping in one extra bit so x0+w / y0+h cannot wrap.
  logic [nX:0]   x_sum, x_lim;
  logic [nY:0]   y_sum, y_lim;
  logic [nX-1:0] x_end_c;
  logic [nY-1:0] y_end_c;
  logic          cmd_empty;

  always_comb begin
    x_sum     = {1'b0, cmd_x0_i} + {1'b0, cmd_w_i};
    y_sum     = {1'b0, cmd_y0_i} + {1'b0, cmd_h_i};
    x_lim     = (x_sum < ColsX) ? x_sum : ColsX;
    y_lim     = (y_sum < RowsY) ? y_sum : RowsY;
    x_end_c   = nX'(x_lim - 1'b1);
    y_end_c   = nY'(y_lim - 1'b1);
    cmd_empty = (cmd_w_i == '0) || (cmd_h_i == '0) ||
                ({1'b0, cmd_x0_i} >= ColsX) || ({1'b0, cmd_y0_i} >= RowsY);
  end

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    x_end_d     = x_end_q;
    y_end_d     = y_end_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    color_d     = color_q;
    cmd_ready_o = 1'b0;
    wr_en_o     = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          color_d = cmd_color_i;
          if (cmd_empty) begin
            state_d = StDone;
          end else begin
            // Cursor only moves for non-empty commands so wr_addr stays on-screen.
            x0_d    = cmd_x0_i;
            x_end_d = x_end_c;
            y_end_d = y_end_c;
            cur_x_d = cmd_x0_i;
            cur_y_d = cmd_y0_i;
            state_d = StFill;
          end
        end
      end
      StFill: begin
        wr_en_o = 1'b1;
        if (wr_ready_i) begin
          if (cur_x_q == x_end_q) begin
            if (cur_y_q == y_end_q) begin
              state_d = StDone;
            end else begin
              cur_x_d = x0_q;
              cur_y_d = cur_y_q + 1'b1;
            end
          end else begin
            cur_x_d = cur_x_q + 1'b1;
          end
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      x0_q    <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      color_q <= color_d;
    end
  end

  assign wr_addr_o = Mn'(cur_y_q) * ColsM + Mn'(cur_x_q);
  assign wr_data_o = color_q;
  assign busy_o    = (state_q != StIdle);

endmodule
